// File: rtl/store_buffer.sv
// store_buffer
//   Word-wide store FIFO sitting between the MEM stage and the data memory.
//   It owns the single memory port: loads always win the port, and buffered
//   stores drain in FIFO order on cycles without a load. Loads that hit a
//   buffered store are served the youngest matching data. A fence stops new
//   stores, waits for the buffer to empty and then pulses out_fence_done.
//
// Ports
//   clk, reset              rising-edge clock, asynchronous active-low reset
//   in_st_valid/addr/data   store request; accepted when out_st_ready is high
//   out_st_ready            buffer can take a store this cycle
//   in_ld_valid/addr        load request (completes in the same cycle)
//   out_ld_data/out_ld_hit  load result and "came from buffer" flag
//   in_fence                one-cycle request to drain everything
//   out_fence_done          one-cycle pulse once the fence has completed
//   out_empty               buffer holds no entries
//   out_mem_*               data memory port (addr, write data, strobes)
//   in_mem_data             combinational read data from data memory
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_st_valid,
  input  logic [ADDR_W-1:0] in_st_addr,
  input  logic [DATA_W-1:0] in_st_data,
  output logic              out_st_ready,
  input  logic              in_ld_valid,
  input  logic [ADDR_W-1:0] in_ld_addr,
  output logic [DATA_W-1:0] out_ld_data,
  output logic              out_ld_hit,
  input  logic              in_fence,
  output logic              out_fence_done,
  output logic              out_empty,
  output logic [ADDR_W-1:0] out_mem_addr,
  output logic [DATA_W-1:0] out_mem_data,
  output logic              out_mem_write,
  output logic              out_mem_read,
  input  logic [DATA_W-1:0] in_mem_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {RUN, FENCE} state_t;

  state_t            state_reg, state_next;
  logic              fence_done_reg, fence_done_next;
  logic [PTR_W-1:0]  head_reg, tail_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [DEPTH-1:0]  valid_reg;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic              full, empty, push, drain;
  logic [DEPTH-1:0]  match;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [PTR_W-1:0]  fwd_idx;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);

  // Ready looks only at the registered occupancy, so a drain in the same
  // cycle never frees a slot for a store early.
  assign out_st_ready = !full && (state_reg == RUN);
  assign push         = in_st_valid && out_st_ready;
  assign drain        = !in_ld_valid && !empty;

  // Memory port: loads own it; otherwise the oldest entry is written out.
  assign out_mem_read  = in_ld_valid;
  assign out_mem_write = drain;
  assign out_mem_addr  = in_ld_valid ? in_ld_addr : addr_mem[head_reg];
  assign out_mem_data  = data_mem[head_reg];
  assign out_empty     = empty;
  assign out_fence_done = fence_done_reg;

  // Per-entry address compare against the load.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi] = valid_reg[gi] && (addr_mem[gi] == in_ld_addr);
    end
  endgenerate

  // Walk entries oldest to youngest starting at head; the last match seen is
  // the youngest, which makes the priority wrap-aware for free.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_reg + PTR_W'(k);
      if (match[fwd_idx]) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[fwd_idx];
      end
    end
  end

  assign out_ld_hit  = in_ld_valid && fwd_hit;
  assign out_ld_data = out_ld_hit ? fwd_data : in_mem_data;

  // Entry payload needs no reset: valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_reg] <= in_st_addr;
      data_mem[tail_reg] <= in_st_data;
    end
  end

  // Pointers, occupancy and valid bits. Push and drain never target the same
  // slot: that would need count of 0 (no drain) or DEPTH (no push).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      valid_reg <= '0;
    end else begin
      if (push) begin
        tail_reg            <= tail_reg + PTR_W'(1);
        valid_reg[tail_reg] <= 1'b1;
      end
      if (drain) begin
        head_reg            <= head_reg + PTR_W'(1);
        valid_reg[head_reg] <= 1'b0;
      end
      case ({push, drain})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Fence state machine.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= RUN;
      fence_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      fence_done_reg <= fence_done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    fence_done_next = 1'b0;
    case (state_reg)
      RUN: begin
        if (in_fence) state_next = FENCE;
      end
      FENCE: begin
        // Extra fence pulses while fencing are simply ignored.
        if (empty) begin
          state_next      = RUN;
          fence_done_next = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_st_valid = 1'b0;
  logic [ADDR_W-1:0] in_st_addr = '0;
  logic [DATA_W-1:0] in_st_data = '0;
  logic              out_st_ready;
  logic              in_ld_valid = 1'b0;
  logic [ADDR_W-1:0] in_ld_addr = '0;
  logic [DATA_W-1:0] out_ld_data;
  logic              out_ld_hit;
  logic              in_fence = 1'b0;
  logic              out_fence_done;
  logic              out_empty;
  logic [ADDR_W-1:0] out_mem_addr;
  logic [DATA_W-1:0] out_mem_data;
  logic              out_mem_write;
  logic              out_mem_read;
  logic [DATA_W-1:0] in_mem_data;

  int n_checks = 0;
  int n_err    = 0;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .in_st_valid(in_st_valid), .in_st_addr(in_st_addr), .in_st_data(in_st_data),
    .out_st_ready(out_st_ready),
    .in_ld_valid(in_ld_valid), .in_ld_addr(in_ld_addr),
    .out_ld_data(out_ld_data), .out_ld_hit(out_ld_hit),
    .in_fence(in_fence), .out_fence_done(out_fence_done), .out_empty(out_empty),
    .out_mem_addr(out_mem_addr), .out_mem_data(out_mem_data),
    .out_mem_write(out_mem_write), .out_mem_read(out_mem_read),
    .in_mem_data(in_mem_data)
  );

  always #5 clk = ~clk;

  // Memory returns a recognisable pattern derived from the address.
  assign in_mem_data = {out_mem_addr[15:0], 16'h5A5A};

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model: a queue of pending stores ----------
  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t m_q[$];
  bit   m_fence = 1'b0;
  bit   m_done  = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_fence = 1'b0;
      m_done  = 1'b0;
    end else begin
      bit do_drain, do_push;
      ent_t e;
      do_drain = !in_ld_valid && (m_q.size() > 0);
      do_push  = in_st_valid && (m_q.size() < DEPTH) && !m_fence;
      m_done   = m_fence && (m_q.size() == 0);
      if (!m_fence && in_fence) m_fence = 1'b1;
      else if (m_fence && m_q.size() == 0) m_fence = 1'b0;
      if (do_drain) void'(m_q.pop_front());
      if (do_push) begin
        e.a = in_st_addr;
        e.d = in_st_data;
        m_q.push_back(e);
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    bit found;
    logic [DATA_W-1:0] fd;
    found = 1'b0;
    fd    = '0;
    chk("m_st_ready", out_st_ready, (m_q.size() < DEPTH) && !m_fence);
    chk("m_empty", out_empty, m_q.size() == 0);
    chk("m_fence_done", out_fence_done, m_done);
    if (in_ld_valid) begin
      for (int i = m_q.size() - 1; i >= 0; i--) begin
        if (!found && m_q[i].a == in_ld_addr) begin
          found = 1'b1;
          fd    = m_q[i].d;
        end
      end
      chk("m_mem_read", out_mem_read, 1);
      chk("m_mem_write", out_mem_write, 0);
      chk("m_mem_addr", out_mem_addr, in_ld_addr);
      chk("m_ld_hit", out_ld_hit, found);
      chk("m_ld_data", out_ld_data, found ? fd : {in_ld_addr[15:0], 16'h5A5A});
    end else if (m_q.size() > 0) begin
      chk("m_mem_read", out_mem_read, 0);
      chk("m_mem_write", out_mem_write, 1);
      chk("m_mem_addr", out_mem_addr, m_q[0].a);
      chk("m_mem_data", out_mem_data, m_q[0].d);
      chk("m_ld_hit", out_ld_hit, 0);
    end else begin
      chk("m_mem_read", out_mem_read, 0);
      chk("m_mem_write", out_mem_write, 0);
      chk("m_ld_hit", out_ld_hit, 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                        input logic lv, input logic [31:0] la, input logic f);
    in_st_valid = sv;
    in_st_addr  = sa;
    in_st_data  = sd;
    in_ld_valid = lv;
    in_ld_addr  = la;
    in_fence    = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    set_in(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Waits for out_fence_done (bounded); ready must stay low until then.
  task automatic wait_fence(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      @(negedge clk);
      if (out_fence_done) begin
        lat = i;
        chk({tag, "_ready_at_done"}, out_st_ready, 1);
      end else begin
        chk({tag, "_ready_low"}, out_st_ready, 0);
      end
      tick();
    end
    chk({tag, "_latency"}, lat, exp_lat);
  endtask

  logic [31:0] exp_a [4];
  logic [31:0] exp_d [4];

  initial begin
    exp_a[0] = 32'h20; exp_d[0] = 32'hAA;
    exp_a[1] = 32'h20; exp_d[1] = 32'hBB;
    exp_a[2] = 32'h30; exp_d[2] = 32'hCC;
    exp_a[3] = 32'h40; exp_d[3] = 32'hDD;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", out_st_ready, 1);
    chk("rst_empty", out_empty, 1);
    chk("rst_write", out_mem_write, 0);
    chk("rst_read", out_mem_read, 0);
    chk("rst_done", out_fence_done, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(1);

    // Single store drains one cycle after its push
    set_in(1, 32'h10, 32'h11, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("s1_write", out_mem_write, 1);
    chk("s1_addr", out_mem_addr, 32'h10);
    chk("s1_data", out_mem_data, 32'h11);
    tick();
    @(negedge clk);
    chk("s1_empty_after", out_empty, 1);
    tick();

    // Fill while a load holds the port
    for (int i = 0; i < 4; i++) begin
      set_in(1, exp_a[i], exp_d[i], 1, 32'h100, 0);
      tick();
    end
    set_in(1, 32'h50, 32'h55, 1, 32'h20, 0);
    @(negedge clk);
    chk("full_ready", out_st_ready, 0);
    chk("full_no_write", out_mem_write, 0);
    chk("fwd_hit", out_ld_hit, 1);
    chk("fwd_data", out_ld_data, 32'hBB);
    tick();
    set_in(0, 0, 0, 1, 32'h24, 0);
    @(negedge clk);
    chk("miss_hit", out_ld_hit, 0);
    chk("miss_data", out_ld_data, 32'h00245A5A);
    tick();
    // Release the load; the first drain cycle must still refuse a store
    for (int i = 0; i < 4; i++) begin
      if (i == 0) set_in(1, 32'h50, 32'h55, 0, 0, 0);
      else        set_in(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      if (i == 0) chk("no_bypass_ready", out_st_ready, 0);
      chk("order_write", out_mem_write, 1);
      chk("order_addr", out_mem_addr, exp_a[i]);
      chk("order_data", out_mem_data, exp_d[i]);
      tick();
    end
    idle(1);

    // Wrap: pointers now at 1, so the 4th push lands in slot 0
    for (int i = 1; i <= 4; i++) begin
      set_in(1, 32'h60, 32'(i), 1, 32'h200, 0);
      tick();
    end
    set_in(0, 0, 0, 1, 32'h60, 0);
    @(negedge clk);
    chk("wrap_hit", out_ld_hit, 1);
    chk("wrap_data", out_ld_data, 32'h4);
    tick();
    idle(5);

    // Back-to-back push and drain
    for (int i = 0; i < 3; i++) begin
      set_in(1, 32'h80 + 32'(4 * i), 32'hC0 + 32'(i), 0, 0, 0);
      tick();
    end
    idle(3);

    // Fence with 3 pending entries
    for (int i = 0; i < 3; i++) begin
      set_in(1, 32'h90 + 32'(4 * i), 32'hE0 + 32'(i), 1, 32'h300, 0);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 1);
    tick();
    set_in(1, 32'h70, 32'h77, 0, 0, 0);
    wait_fence("fence3", 4);
    idle(3);

    // Fence with an empty buffer
    set_in(0, 0, 0, 0, 0, 1);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    wait_fence("fence0", 2);
    idle(1);

    // Reset while two stores are pending
    for (int i = 0; i < 2; i++) begin
      set_in(1, 32'hA0 + 32'(4 * i), 32'hF0 + 32'(i), 1, 32'h400, 0);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    chk("rstmid_empty", out_empty, 1);
    chk("rstmid_write", out_mem_write, 0);
    chk("rstmid_ready", out_st_ready, 1);
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstmid_no_write", out_mem_write, 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
